// File: rtl/dpram_rw_arbiter_if.sv
// dpram_rw_arbiter_if: requester-side and RAM-side signals of the shared dual-port SRAM arbiter.
interface dpram_rw_arbiter_if #(
   parameter int NUM_MASTER = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_MASTER-1:0]            rd_req;
   logic [NUM_MASTER*ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_MASTER-1:0]            rd_gnt;
   logic [NUM_MASTER-1:0]            wr_req;
   logic [NUM_MASTER*ADDR_WIDTH-1:0] wr_addr;
   logic [NUM_MASTER*DATA_WIDTH-1:0] wr_data;
   logic [NUM_MASTER-1:0]            wr_gnt;
   logic                             rdata_valid;
   logic [NUM_MASTER-1:0]            rdata_id;
   logic [DATA_WIDTH-1:0]            rdata;
   logic                             ram_we;
   logic [ADDR_WIDTH-1:0]            ram_waddr;
   logic [DATA_WIDTH-1:0]            ram_wdata;
   logic                             ram_rd;
   logic [ADDR_WIDTH-1:0]            ram_raddr;
   logic [DATA_WIDTH-1:0]            ram_rdata;
   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
      output rd_gnt, wr_gnt, rdata_valid, rdata_id, rdata,
             ram_we, ram_waddr, ram_wdata, ram_rd, ram_raddr
   );
   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_rdata,
      input  rd_gnt, wr_gnt, rdata_valid, rdata_id, rdata,
             ram_we, ram_waddr, ram_wdata, ram_rd, ram_raddr
   );
endinterface

// File: rtl/dpram_rw_arbiter.sv
// dpram_rw_arbiter: independent round-robin read/write arbitration onto one dual-port SRAM with write-to-read forwarding.
module dpram_rw_arbiter #(
   parameter int NUM_MASTER = 4,
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input logic              clk,
   input logic              rst_b,
   dpram_rw_arbiter_if.slave bus
);
   localparam int PW = $clog2(NUM_MASTER);

   function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int j);
      int s;
      s = (int'(p) + j) % NUM_MASTER;
      return PW'(s);
   endfunction

   logic [PW-1:0]         r_rd_ptr, r_wr_ptr;
   logic [PW-1:0]         w_rd_sel, w_wr_sel;
   logic [NUM_MASTER-1:0] w_rd_gnt, w_wr_gnt;
   logic                  r_rdata_valid, r_byp_hit;
   logic [NUM_MASTER-1:0] r_rdata_id;
   logic [DATA_WIDTH-1:0] r_byp_data;

   // Scan from the farthest offset back to rr_ptr so the nearest requester overwrites last.
   always_comb begin
      w_rd_gnt = '0;
      w_wr_gnt = '0;
      w_rd_sel = '0;
      w_wr_sel = '0;
      for (int j = NUM_MASTER - 1; j >= 0; j--) begin
         if (bus.rd_req[wrap(r_rd_ptr, j)]) begin
            w_rd_sel = wrap(r_rd_ptr, j);
            w_rd_gnt = NUM_MASTER'(1) << w_rd_sel;
         end
         if (bus.wr_req[wrap(r_wr_ptr, j)]) begin
            w_wr_sel = wrap(r_wr_ptr, j);
            w_wr_gnt = NUM_MASTER'(1) << w_wr_sel;
         end
      end
   end

   assign bus.rd_gnt    = w_rd_gnt;
   assign bus.wr_gnt    = w_wr_gnt;
   assign bus.ram_rd    = |w_rd_gnt;
   assign bus.ram_we    = |w_wr_gnt;
   assign bus.ram_raddr = bus.ram_rd ? bus.rd_addr[w_rd_sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign bus.ram_waddr = bus.ram_we ? bus.wr_addr[w_wr_sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign bus.ram_wdata = bus.ram_we ? bus.wr_data[w_wr_sel*DATA_WIDTH +: DATA_WIDTH] : '0;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_rdata_valid <= 1'b0;
         r_rdata_id    <= '0;
         r_byp_hit     <= 1'b0;
         r_byp_data    <= '0;
      end else begin
         if (bus.ram_rd) r_rd_ptr <= wrap(w_rd_sel, 1);
         if (bus.ram_we) r_wr_ptr <= wrap(w_wr_sel, 1);
         r_rdata_valid <= bus.ram_rd;
         r_rdata_id    <= w_rd_gnt;
         r_byp_hit     <= bus.ram_rd & bus.ram_we & (bus.ram_raddr == bus.ram_waddr);
         r_byp_data    <= bus.ram_wdata;
      end
   end

   // The RAM returns stale contents on a same-address collision, so forward the written word.
   assign bus.rdata_valid = r_rdata_valid;
   assign bus.rdata_id    = r_rdata_id;
   assign bus.rdata       = !r_rdata_valid ? '0 : r_byp_hit ? r_byp_data : bus.ram_rdata;
endmodule
